// File: rtl/instr_loader.sv
// Instruction loader: encodes symbolic MIPS fields into 32-bit words and writes
// them sequentially into instruction memory over a valid/ready handshake.
module instr_loader #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2:0]            op_class,
    input  logic [4:0]            rs,
    input  logic [4:0]            rt,
    input  logic [4:0]            rd,
    input  logic [4:0]            shamt,
    input  logic [5:0]            funct,
    input  logic [15:0]           imm,
    input  logic [25:0]           target,
    input  logic                  finish,
    input  logic                  flush,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  full,
    output logic                  done,
    output logic                  err
);

    // state | meaning
    // LOAD  | accepting instructions
    // FULL  | memory filled, waiting for finish or flush
    // DONE  | program closed, idle until flush
    typedef enum logic [1:0] {
        LOAD = 2'd0,
        FULL = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [ADDR_WIDTH:0] DEPTH_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};

    state_t              state, state_next;
    logic                accept;
    logic                supported;
    logic [31:0]         enc_word;
    logic [ADDR_WIDTH:0] count_inc;

    assign in_ready = (state == LOAD) && (count != DEPTH_CNT) && !rst && !flush;
    assign full     = (count == DEPTH_CNT);
    assign done     = (state == DONE);

    always_comb begin
        accept    = in_valid && in_ready;
        supported = (op_class != 3'd6) && (op_class != 3'd7);
        count_inc = count + 1'b1;
        enc_word  = 32'd0;
        case (op_class)
            3'd0:    enc_word = {6'd0, rs, rt, rd, shamt, funct};
            3'd1:    enc_word = {6'd35, rs, rt, imm};
            3'd2:    enc_word = {6'd43, rs, rt, imm};
            3'd3:    enc_word = {6'd4, rs, rt, imm};
            3'd4:    enc_word = {6'd2, target};
            3'd5:    enc_word = {6'd8, rs, rt, imm};
            default: enc_word = 32'd0;
        endcase

        state_next = state;
        if (flush) begin
            state_next = LOAD;
        end else begin
            case (state)
                LOAD: begin
                    if (finish)
                        state_next = DONE;
                    else if (accept && supported && (count_inc == DEPTH_CNT))
                        state_next = FULL;
                end
                FULL:    if (finish) state_next = DONE;
                DONE:    state_next = DONE;
                default: state_next = LOAD;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= LOAD;
        else
            state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= 32'd0;
            count      <= '0;
            err        <= 1'b0;
        end else if (flush) begin
            // address/data hold their last values; only the strobe matters
            imem_we <= 1'b0;
            count   <= '0;
            err     <= 1'b0;
        end else begin
            imem_we <= accept && supported;
            if (accept && supported) begin
                imem_wdata <= enc_word;
                imem_addr  <= count[ADDR_WIDTH-1:0];
                count      <= count_inc;
            end
            if (accept && !supported)
                err <= 1'b1;
        end
    end

endmodule
